// File: rtl/pcmcia_spi_bridge.sv
`timescale 1ns/1ps
// pcmcia_spi_bridge
// Bridges PC Card I/O-space register accesses onto an 8-bit SPI mode-0 master.
//
// Ports:
//   clk_26  - system clock (26 MHz)
//   RESETB  - asynchronous active-low reset
//   A       - register select (0 DATA, 1 STATUS, 2 CTRL, 3 DIV)
//   D_in    - host write data
//   CE1     - card enable, active low
//   IOWR    - I/O write strobe, active low, asynchronous to clk_26
//   IORD    - I/O read strobe, active low, asynchronous to clk_26
//   D_out   - read data, 0 when the card is not driving
//   DDIR    - 1 while the card drives the data bus
//   INPACK  - input acknowledge, active low
//   SS      - SPI slave select, active low, software controlled (CTRL.ss_en)
//   SCLK    - SPI clock, idles low
//   MOSI    - SPI data out, MSB first
//   MISO    - SPI data in, sampled on the SCLK rising edge
//   INT     - interrupt request, rx_valid & CTRL.ien
module pcmcia_spi_bridge #(
  parameter logic [7:0] DIV_RESET = 8'd12
) (
  input  logic       clk_26,
  input  logic       RESETB,
  input  logic [1:0] A,
  input  logic [7:0] D_in,
  input  logic       CE1,
  input  logic       IOWR,
  input  logic       IORD,
  output logic [7:0] D_out,
  output logic       DDIR,
  output logic       INPACK,
  output logic       SS,
  output logic       SCLK,
  output logic       MOSI,
  input  logic       MISO,
  output logic       INT
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Strobe synchronizers: stage 3 only serves the edge detector.
  logic       iowr_s1_q, iowr_s2_q, iowr_s3_q;
  logic       rd0_s1_q, rd0_s2_q, rd0_s3_q;
  logic [1:0] wr_addr_q;
  logic [7:0] wr_data_q;

  // Architectural and SPI state.
  state_t     state_q, state_d;
  logic [1:0] ctrl_q, ctrl_d;
  logic [7:0] div_q, div_d;
  logic [7:0] rx_q, rx_d;
  logic       rx_valid_q, rx_valid_d;
  logic       overrun_q, overrun_d;
  logic [7:0] hcnt_q, hcnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       miso_q, miso_d;
  logic       sclk_q, sclk_d;
  logic       mosi_q, mosi_d;

  logic       iowr_gated_s;
  logic       rd0_sel_s;
  logic       iowr_rise_s;
  logic       rd0_end_s;
  logic       busy_s;
  logic [7:0] status_s;

  // A write only counts while the card is enabled.
  assign iowr_gated_s = IOWR | CE1;
  // Active-high "DATA register is being read"; its falling edge clears rx_valid.
  assign rd0_sel_s    = ~IORD & ~CE1 & (A == 2'd0);

  assign iowr_rise_s  = iowr_s2_q & ~iowr_s3_q;
  assign rd0_end_s    = ~rd0_s2_q & rd0_s3_q;
  assign busy_s       = (state_q != ST_IDLE);
  assign status_s     = {5'd0, overrun_q, rx_valid_q, busy_s};

  // Strobe synchronizers and write address/data capture.
  always_ff @(posedge clk_26 or negedge RESETB) begin
    if (!RESETB) begin
      iowr_s1_q <= 1'b1;
      iowr_s2_q <= 1'b1;
      iowr_s3_q <= 1'b1;
      rd0_s1_q  <= 1'b0;
      rd0_s2_q  <= 1'b0;
      rd0_s3_q  <= 1'b0;
      wr_addr_q <= 2'd0;
      wr_data_q <= 8'd0;
    end else begin
      iowr_s1_q <= iowr_gated_s;
      iowr_s2_q <= iowr_s1_q;
      iowr_s3_q <= iowr_s2_q;
      rd0_s1_q  <= rd0_sel_s;
      rd0_s2_q  <= rd0_s1_q;
      rd0_s3_q  <= rd0_s2_q;
      // Keep sampling while the synchronized strobe is low so the last
      // sample before the rising edge is the one committed.
      if (!iowr_s2_q) begin
        wr_addr_q <= A;
        wr_data_q <= D_in;
      end
    end
  end

  // State register for the register file and SPI engine.
  always_ff @(posedge clk_26 or negedge RESETB) begin
    if (!RESETB) begin
      state_q    <= ST_IDLE;
      ctrl_q     <= 2'd0;
      div_q      <= DIV_RESET;
      rx_q       <= 8'd0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      hcnt_q     <= 8'd0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      miso_q     <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      div_q      <= div_d;
      rx_q       <= rx_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      hcnt_q     <= hcnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      miso_q     <= miso_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
    end
  end

  // Register writes, flag updates and SPI next-state logic.
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    div_d      = div_q;
    rx_d       = rx_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    hcnt_d     = hcnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    miso_d     = miso_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;

    if (iowr_rise_s) begin
      case (wr_addr_q)
        2'd0: begin
          // DATA while busy (DONE included) is dropped and flagged.
          if (busy_s) begin
            overrun_d = 1'b1;
          end else begin
            overrun_d = overrun_q;
          end
        end
        2'd1: begin
          if (wr_data_q[2]) begin
            overrun_d = 1'b0;
          end else begin
            overrun_d = overrun_q;
          end
        end
        2'd2:    ctrl_d = wr_data_q[1:0];
        2'd3:    div_d  = wr_data_q;
        default: ctrl_d = ctrl_q;
      endcase
    end else begin
      ctrl_d = ctrl_q;
    end

    if (rd0_end_s) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (iowr_rise_s && (wr_addr_q == 2'd0)) begin
          shift_d   = wr_data_q;
          mosi_d    = wr_data_q[7];
          bit_cnt_d = 3'd0;
          hcnt_d    = div_q;
          state_d   = ST_LOW;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_LOW: begin
        if (hcnt_q == 8'd0) begin
          sclk_d  = 1'b1;
          // Held aside so MOSI keeps the current bit until the falling edge.
          miso_d  = MISO;
          hcnt_d  = div_q;
          state_d = ST_HIGH;
        end else begin
          hcnt_d  = hcnt_q - 8'd1;
        end
      end
      ST_HIGH: begin
        if (hcnt_q == 8'd0) begin
          sclk_d  = 1'b0;
          shift_d = {shift_q[6:0], miso_q};
          hcnt_d  = div_q;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_DONE;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            mosi_d    = shift_q[6];
            state_d   = ST_LOW;
          end
        end else begin
          hcnt_d  = hcnt_q - 8'd1;
        end
      end
      ST_DONE: begin
        // Placed after the read-clear so a coincident clear loses.
        rx_d       = shift_q;
        rx_valid_d = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read path: combinational from the raw bus pins.
  always_comb begin
    D_out  = 8'd0;
    DDIR   = 1'b0;
    INPACK = 1'b1;
    if (!CE1 && !IORD) begin
      DDIR   = 1'b1;
      INPACK = 1'b0;
      case (A)
        2'd0:    D_out = rx_q;
        2'd1:    D_out = status_s;
        2'd2:    D_out = {6'd0, ctrl_q};
        2'd3:    D_out = div_q;
        default: D_out = 8'd0;
      endcase
    end else begin
      D_out = 8'd0;
    end
  end

  assign SS   = ~ctrl_q[0];
  assign SCLK = sclk_q;
  assign MOSI = mosi_q;
  assign INT  = rx_valid_q & ctrl_q[1];

endmodule

// File: tb/tb_pcmcia_spi_bridge.sv
`timescale 1ns/1ps
// Directed bench for pcmcia_spi_bridge with MISO looped back to MOSI.
module tb_pcmcia_spi_bridge;

  logic       clk_26 = 1'b0;
  logic       RESETB = 1'b0;
  logic [1:0] A      = 2'd0;
  logic [7:0] D_in   = 8'd0;
  logic       CE1    = 1'b1;
  logic       IOWR   = 1'b1;
  logic       IORD   = 1'b1;
  logic [7:0] D_out;
  logic       DDIR, INPACK, SS, SCLK, MOSI, MISO, INT;

  int n_checks = 0;
  int n_pass   = 0;

  // SCLK-edge monitor: shift in MOSI on every rising edge.
  logic [7:0] mon_byte = 8'd0;
  int         mon_cnt  = 0;

  assign MISO = MOSI;

  pcmcia_spi_bridge #(.DIV_RESET(8'd12)) dut (
    .clk_26(clk_26), .RESETB(RESETB), .A(A), .D_in(D_in), .CE1(CE1),
    .IOWR(IOWR), .IORD(IORD), .D_out(D_out), .DDIR(DDIR), .INPACK(INPACK),
    .SS(SS), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .INT(INT)
  );

  // 26 MHz-ish clock.
  always #19 clk_26 = ~clk_26;

  // Record MOSI bits as the slave would see them.
  always @(posedge SCLK) begin
    mon_byte = {mon_byte[6:0], MOSI};
    mon_cnt  = mon_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Drive a write strobe; returns on the negedge where IOWR rises (A/D held).
  task automatic wr_reg(input logic [1:0] addr, input logic [7:0] val);
    @(negedge clk_26);
    A = addr; D_in = val; CE1 = 1'b0; IOWR = 1'b0;
    repeat (4) @(negedge clk_26);
    IOWR = 1'b1;
  endtask

  // Full read cycle including the synchronized read side effect.
  task automatic rd_reg(input logic [1:0] addr, output logic [7:0] val);
    @(negedge clk_26);
    A = addr; CE1 = 1'b0; IORD = 1'b0;
    #1;
    val = D_out;
    check_val("rd_ddir", {31'd0, DDIR}, 32'd1);
    check_val("rd_inpack", {31'd0, INPACK}, 32'd0);
    repeat (3) @(negedge clk_26);
    IORD = 1'b1;
    repeat (4) @(negedge clk_26);
  endtask

  // Count negedges from the write strobe's rise until INT, tracking SCLK.
  task automatic measure_xfer(input int limit, output int t_int, output int t_first,
                              output int t_last, output int toggles, output int hi_w);
    logic prev;
    int   hi;
    prev = SCLK; hi = 0; t_int = 0; t_first = -1; t_last = -1; toggles = 0; hi_w = 0;
    while (!INT && t_int < limit) begin
      @(negedge clk_26);
      t_int++;
      if (SCLK !== prev) toggles++;
      if (SCLK && !prev) begin
        if (t_first < 0) t_first = t_int;
        t_last = t_int;
        hi = 0;
      end
      if (SCLK) hi++;
      else if (prev) hi_w = hi;
      prev = SCLK;
    end
    check_val("xfer_int_seen", {31'd0, INT}, 32'd1);
  endtask

  initial begin
    logic [7:0] rd;
    int t_int, t_first, t_last, tog, hw, base, n;

    // ---- Reset ----
    repeat (3) @(negedge clk_26);
    check_val("rst_ss", {31'd0, SS}, 32'd1);
    check_val("rst_sclk", {31'd0, SCLK}, 32'd0);
    check_val("rst_mosi", {31'd0, MOSI}, 32'd0);
    check_val("rst_int", {31'd0, INT}, 32'd0);
    check_val("rst_ddir", {31'd0, DDIR}, 32'd0);
    check_val("rst_inpack", {31'd0, INPACK}, 32'd1);
    check_val("rst_dout", {24'd0, D_out}, 32'd0);
    RESETB = 1'b1;
    rd_reg(2'd3, rd); check_val("rst_div", {24'd0, rd}, 32'h0C);
    rd_reg(2'd2, rd); check_val("rst_ctrl", {24'd0, rd}, 32'h00);
    rd_reg(2'd1, rd); check_val("rst_status", {24'd0, rd}, 32'h00);
    rd_reg(2'd0, rd); check_val("rst_rx", {24'd0, rd}, 32'h00);

    // ---- Loopback, DIV=12 ----
    wr_reg(2'd2, 8'h03);
    repeat (4) @(negedge clk_26);
    check_val("lb_ss", {31'd0, SS}, 32'd0);
    base = mon_cnt;
    wr_reg(2'd0, 8'hA5);
    measure_xfer(400, t_int, t_first, t_last, tog, hw);
    check_val("lb_bits", {24'd0, mon_byte}, 32'hA5);
    check_val("lb_pulses", mon_cnt - base, 32'd8);
    check_val("lb_first_rise", t_first, 32'd16);
    check_val("lb_last_rise", t_last, 32'd198);
    check_val("lb_high_width", hw, 32'd13);
    check_val("lb_toggles", tog, 32'd16);
    check_val("lb_int_latency", t_int, 32'd212);
    rd_reg(2'd1, rd); check_val("lb_status", {24'd0, rd}, 32'h02);
    check_val("lb_int", {31'd0, INT}, 32'd1);
    rd_reg(2'd0, rd); check_val("lb_rx", {24'd0, rd}, 32'hA5);
    rd_reg(2'd1, rd); check_val("lb_status_clr", {24'd0, rd}, 32'h00);
    check_val("lb_int_clr", {31'd0, INT}, 32'd0);

    // ---- Divider = 0 ----
    wr_reg(2'd3, 8'h00);
    repeat (4) @(negedge clk_26);
    base = mon_cnt;
    wr_reg(2'd0, 8'h3C);
    measure_xfer(100, t_int, t_first, t_last, tog, hw);
    check_val("div0_first_rise", t_first, 32'd4);
    check_val("div0_toggles", tog, 32'd16);
    check_val("div0_high_width", hw, 32'd1);
    check_val("div0_int_latency", t_int, 32'd20);
    check_val("div0_bits", {24'd0, mon_byte}, 32'h3C);
    rd_reg(2'd0, rd); check_val("div0_rx", {24'd0, rd}, 32'h3C);

    // ---- Overrun, DIV=3 ----
    wr_reg(2'd3, 8'h03);
    repeat (4) @(negedge clk_26);
    base = mon_cnt;
    wr_reg(2'd0, 8'h11);
    repeat (10) @(negedge clk_26);
    rd_reg(2'd1, rd); check_val("ovr_busy", {24'd0, rd}, 32'h01);
    wr_reg(2'd0, 8'h22);
    measure_xfer(200, t_int, t_first, t_last, tog, hw);
    check_val("ovr_bits", {24'd0, mon_byte}, 32'h11);
    check_val("ovr_pulses", mon_cnt - base, 32'd8);
    rd_reg(2'd1, rd); check_val("ovr_status", {24'd0, rd}, 32'h06);
    wr_reg(2'd1, 8'h04);
    repeat (4) @(negedge clk_26);
    rd_reg(2'd1, rd); check_val("ovr_status_clr", {24'd0, rd}, 32'h02);
    rd_reg(2'd0, rd); check_val("ovr_rx", {24'd0, rd}, 32'h11);

    // ---- Read decode ----
    @(negedge clk_26);
    A = 2'd2; CE1 = 1'b1; IORD = 1'b0;
    #1;
    check_val("dec_off_ddir", {31'd0, DDIR}, 32'd0);
    check_val("dec_off_inpack", {31'd0, INPACK}, 32'd1);
    check_val("dec_off_dout", {24'd0, D_out}, 32'd0);
    CE1 = 1'b0;
    #1;
    check_val("dec_on_ddir", {31'd0, DDIR}, 32'd1);
    check_val("dec_on_inpack", {31'd0, INPACK}, 32'd0);
    check_val("dec_on_dout", {24'd0, D_out}, 32'h03);
    @(negedge clk_26);
    IORD = 1'b1; CE1 = 1'b1;
    repeat (4) @(negedge clk_26);

    // ---- Reset mid-transfer ----
    base = mon_cnt;
    wr_reg(2'd0, 8'hF0);
    n = 0;
    while ((mon_cnt - base) < 3 && n < 200) begin
      @(negedge clk_26);
      n++;
    end
    check_val("mid_three_bits", mon_cnt - base, 32'd3);
    repeat (2) @(negedge clk_26);
    RESETB = 1'b0;
    #1;
    check_val("mid_rst_sclk", {31'd0, SCLK}, 32'd0);
    check_val("mid_rst_ss", {31'd0, SS}, 32'd1);
    check_val("mid_rst_mosi", {31'd0, MOSI}, 32'd0);
    @(negedge clk_26);
    RESETB = 1'b1;
    rd_reg(2'd1, rd); check_val("mid_status", {24'd0, rd}, 32'h00);
    rd_reg(2'd0, rd); check_val("mid_rx", {24'd0, rd}, 32'h00);
    rd_reg(2'd3, rd); check_val("mid_div", {24'd0, rd}, 32'h0C);
    wr_reg(2'd2, 8'h03);
    repeat (4) @(negedge clk_26);
    base = mon_cnt;
    wr_reg(2'd0, 8'h5A);
    measure_xfer(400, t_int, t_first, t_last, tog, hw);
    check_val("post_int_latency", t_int, 32'd212);
    check_val("post_pulses", mon_cnt - base, 32'd8);
    check_val("post_bits", {24'd0, mon_byte}, 32'h5A);
    rd_reg(2'd0, rd); check_val("post_rx", {24'd0, rd}, 32'h5A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
